// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command front-end for the n-bit combinational ALU.
// It queues commands in a small FIFO, drives registered ALU inputs, and
// captures the result one cycle later with flags. The result is presented
// on a valid/ready output. An accumulator lets operand A chain from the
// previous result.
module alu_cmd_issue #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_use_acc,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_sel,
    output logic         alu_ctrl,
    input  logic [N-1:0] alu_y,
    input  logic         alu_cout,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_y,
    output logic         res_carry,
    output logic         res_zero,
    output logic         res_neg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_SUB = 3'b001;

    typedef struct packed {
        logic [2:0]   op;
        logic         use_acc;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    // The FIFO is tiny, so the head is read combinationally. The FSM can then
    // pop and load the ALU registers in the same edge.
    cmd_t            fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    cmd_t            head;
    cmd_t            cmd_in;

    state_t          state_q;
    logic [N-1:0]    acc_q;
    logic [N-1:0]    alu_a_q, alu_b_q;
    logic [2:0]      alu_sel_q;
    logic            alu_ctrl_q;
    logic            res_valid_q;
    logic [N-1:0]    res_y_q;
    logic            res_carry_q, res_zero_q, res_neg_q;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr_q];

    assign cmd_in.op      = cmd_op;
    assign cmd_in.use_acc = cmd_use_acc;
    assign cmd_in.a       = cmd_a;
    assign cmd_in.b       = cmd_b;

    // Next-state for FIFO pointers and occupancy. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointer and occupancy registers; reset discards queued commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------- issue / capture FSM ----------------
    // Only one command is in flight at a time. A use_acc command therefore
    // always sees the result of the command immediately before it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_ctrl_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_q    <= head.use_acc ? acc_q : head.a;
                        alu_b_q    <= head.b;
                        alu_sel_q  <= head.op;
                        alu_ctrl_q <= (head.op == OP_SUB);
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The ALU settled during this cycle, so capture it now.
                    // The carry is only meaningful for add/sub (ops 000 and 001).
                    res_y_q     <= alu_y;
                    acc_q       <= alu_y;
                    res_carry_q <= (alu_sel_q[2:1] == 2'b00) ? alu_cout : 1'b0;
                    res_zero_q  <= (alu_y == '0);
                    res_neg_q   <= alu_y[N-1];
                    res_valid_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with a behavioural model of the ALU.
module tb_alu_cmd_issue;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         cmd_use_acc;
    logic [N-1:0] cmd_a, cmd_b;
    logic [N-1:0] alu_a, alu_b;
    logic [2:0]   alu_sel;
    logic         alu_ctrl;
    logic [N-1:0] alu_y;
    logic         alu_cout;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_y;
    logic         res_carry, res_zero, res_neg;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    alu_cmd_issue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_use_acc (cmd_use_acc),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_ctrl    (alu_ctrl),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_y       (res_y),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_neg     (res_neg)
    );

    // Behavioural ALU: a ripple adder whose carry is always produced, plus logic ops.
    logic [N:0]   sum;
    logic [N-1:0] b_eff;
    always_comb begin
        b_eff    = alu_ctrl ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, b_eff} + (N+1)'(alu_ctrl);
        alu_cout = sum[N];
        case (alu_sel)
            3'b000, 3'b001: alu_y = sum[N-1:0];
            3'b010:         alu_y = alu_a & alu_b;
            3'b011:         alu_y = alu_a | alu_b;
            3'b100:         alu_y = ~(alu_a & alu_b);
            3'b101:         alu_y = ~(alu_a | alu_b);
            3'b110:         alu_y = alu_a ^ alu_b;
            default:        alu_y = ~(alu_a ^ alu_b);
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] op, input logic acc,
                           input logic [N-1:0] a, input logic [N-1:0] b);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_use_acc = acc;
        cmd_a       = a;
        cmd_b       = b;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (!res_valid && g < 20) begin
            step();
            g++;
        end
        chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
    endtask

    // One command from an idle, empty front-end, with exact latency checks.
    task automatic do_op(input string tag, input logic [2:0] op, input logic acc,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_a, input logic [N-1:0] exp_y,
                         input logic exp_c);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        set_cmd(1'b1, op, acc, a, b);
        step();
        cmd_valid = 1'b0;
        step();
        chk({tag, "_alu_a"},    32'(alu_a),    32'(exp_a));
        chk({tag, "_alu_b"},    32'(alu_b),    32'(b));
        chk({tag, "_alu_sel"},  32'(alu_sel),  32'(op));
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), (op == 3'b001) ? 32'd1 : 32'd0);
        chk({tag, "_early"},    32'(res_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_y"},     32'(res_y),     32'(exp_y));
        chk({tag, "_carry"}, 32'(res_carry), 32'(exp_c));
        chk({tag, "_zero"},  32'(res_zero),  (exp_y == '0) ? 32'd1 : 32'd0);
        chk({tag, "_neg"},   32'(res_neg),   32'(exp_y[N-1]));
        $display("txn %s: op=%0d a=%0h b=%0h -> y=%0h c=%0b", tag, op, a, b, res_y, res_carry);
        res_ready = 1'b1;
        step();
        chk({tag, "_consumed"}, 32'(res_valid), 32'd0);
        res_ready = 1'b0;
    endtask

    initial begin
        int last;
        logic [N-1:0] exp_v;

        rst_n     = 1'b0;
        res_ready = 1'b0;
        set_cmd(1'b0, 3'b000, 1'b0, '0, '0);
        step();
        step();

        // Reset state
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_alu_sel",   32'(alu_sel),   32'd0);
        chk("rst_alu_ctrl",  32'(alu_ctrl),  32'd0);
        chk("rst_res_y",     32'(res_y),     32'd0);
        chk("rst_flags",     {29'd0, res_carry, res_zero, res_neg}, 32'd0);
        rst_n = 1'b1;
        step();

        // Arithmetic and logic with chaining
        do_op("add5p3",  3'b000, 1'b0, 4'd5,     4'd3,     4'd5,     4'b1000, 1'b0);
        do_op("sub3m3",  3'b001, 1'b0, 4'd3,     4'd3,     4'd3,     4'b0000, 1'b1);
        do_op("add9p9",  3'b000, 1'b0, 4'd9,     4'd9,     4'd9,     4'b0010, 1'b1);
        do_op("and",     3'b010, 1'b0, 4'b1100,  4'b1010,  4'b1100,  4'b1000, 1'b0);
        do_op("or_acc",  3'b011, 1'b1, 4'b1111,  4'b0001,  4'b1000,  4'b1001, 1'b0);
        do_op("sub2m7",  3'b001, 1'b0, 4'd2,     4'd7,     4'd2,     4'b1011, 1'b0);
        do_op("xnor",    3'b111, 1'b0, 4'b1100,  4'b1010,  4'b1100,  4'b1001, 1'b0);

        // FIFO full with backpressure
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_push%0d_ready", i), 32'(cmd_ready), 32'd1);
            set_cmd(1'b1, 3'b000, 1'b0, 4'(i + 1), 4'(i));
            step();
        end
        cmd_valid = 1'b0;
        chk("full_cmd_ready_low", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("hold%0d_y", i),     32'(res_y),     32'd1);
            step();
        end
        res_ready = 1'b1;
        last = 0;
        for (int j = 0; j < 5; j++) begin
            wait_valid($sformatf("drain%0d", j));
            exp_v = 4'(2 * j + 1);
            chk($sformatf("drain%0d_y", j), 32'(res_y), 32'(exp_v));
            if (j > 0) begin
                chk($sformatf("drain%0d_gap", j), 32'(cyc - last), 32'd3);
            end
            $display("txn drain%0d: y=%0h at cycle %0d", j, res_y, cyc);
            last = cyc;
            step();
        end
        step();
        step();
        chk("drain_done_valid", 32'(res_valid), 32'd0);
        chk("drain_done_ready", 32'(cmd_ready), 32'd1);

        // Simultaneous push and pop with one entry queued
        set_cmd(1'b1, 3'b110, 1'b0, 4'b0110, 4'b0011);
        step();
        set_cmd(1'b1, 3'b001, 1'b0, 4'd2, 4'd7);
        step();
        cmd_valid = 1'b0;
        chk("pushpop_count", 32'(dut.count_q), 32'd1);
        wait_valid("pp0");
        chk("pp0_y",     32'(res_y),     32'b0101);
        chk("pp0_carry", 32'(res_carry), 32'd0);
        $display("txn pp0: y=%0h", res_y);
        step();
        wait_valid("pp1");
        chk("pp1_y",     32'(res_y),     32'b1011);
        chk("pp1_carry", 32'(res_carry), 32'd0);
        chk("pp1_neg",   32'(res_neg),   32'd1);
        $display("txn pp1: y=%0h", res_y);
        step();
        res_ready = 1'b0;
        step();

        // Reset mid-operation with three commands queued
        set_cmd(1'b1, 3'b000, 1'b0, 4'd7, 4'd0);
        step();
        set_cmd(1'b1, 3'b001, 1'b0, 4'd9, 4'd6);
        step();
        set_cmd(1'b1, 3'b011, 1'b0, 4'd1, 4'd2);
        step();
        set_cmd(1'b1, 3'b010, 1'b0, 4'd3, 4'd4);
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_y", 32'(res_y), 32'd7);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        set_cmd(1'b1, 3'b000, 1'b0, 4'd5, 4'd5);
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_count", 32'(dut.count_q), 32'd3);
        chk("pre_rst_alu_a", 32'(alu_a), 32'd9);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid",    32'(res_valid), 32'd0);
        chk("midrst_ready",    32'(cmd_ready), 32'd1);
        chk("midrst_alu_a",    32'(alu_a),     32'd0);
        chk("midrst_alu_b",    32'(alu_b),     32'd0);
        chk("midrst_alu_sel",  32'(alu_sel),   32'd0);
        chk("midrst_alu_ctrl", 32'(alu_ctrl),  32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("midrst_no_result", 32'(res_valid), 32'd0);
        do_op("acc_after_rst", 3'b000, 1'b1, 4'b1111, 4'b0010, 4'd0, 4'b0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
